// File: rtl/magnitude_comparator_4bit_pkg.sv
// Shared types for the magnitude comparator: one-hot {GT, EQ, LT} result encoding
// and the cascade resolution used when the local operands are equal.
package magnitude_comparator_4bit_pkg;

  typedef enum logic [2:0] {
    CMP_LT = 3'b001,
    CMP_EQ = 3'b010,
    CMP_GT = 3'b100
  } cmp_result_t;

  localparam logic [2:0] CMP_NONE = 3'b000;

  // Lower-order slice verdict: greater wins over less, anything else is equal.
  function automatic cmp_result_t cascadeResult(input logic gt, input logic eq, input logic lt);
    cmp_result_t res;
    casez ({gt, lt, eq})
      3'b1??:  res = CMP_GT;
      3'b01?:  res = CMP_LT;
      default: res = CMP_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/magnitude_cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands with 74x85-style cascade
// inputs; the verdict is taken at the most-significant differing bit.
module magnitude_cmp_core
  import magnitude_comparator_4bit_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_gt,
  input  logic             i_eq,
  input  logic             i_lt,
  output cmp_result_t      o_result
);

  cmp_result_t w_result;

  // Scanning upward lets the highest differing bit overwrite lower ones; in signed
  // mode a set MSB means negative, so its sense is inverted.
  always_comb begin
    w_result = cascadeResult(i_gt, i_eq, i_lt);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_a[i] != i_b[i]) begin
        w_result = (i_a[i] ^ (SIGNED && (i == WIDTH - 1))) ? CMP_GT : CMP_LT;
      end
    end
  end

  assign o_result = w_result;

endmodule

// File: rtl/magnitude_comparator_4bit.sv
// Registered magnitude comparator: qualified inputs load a one-hot result one cycle
// later; flags hold while idle and clear on synchronous active-low reset.
module magnitude_comparator_4bit
  import magnitude_comparator_4bit_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             out_valid,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less
);

  cmp_result_t w_result;
  logic [2:0]  r_flags;
  logic        r_valid;

  magnitude_cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .i_a      (A),
    .i_b      (B),
    .i_gt     (gt_in),
    .i_eq     (eq_in),
    .i_lt     (lt_in),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_flags <= CMP_NONE;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_flags <= w_result;
      end
    end
  end

  assign out_valid = r_valid;
  assign A_greater = r_flags[2];
  assign A_equal   = r_flags[1];
  assign A_less    = r_flags[0];

endmodule

// File: tb/tb_magnitude_comparator_4bit.sv
// Scoreboard bench: unsigned and signed instances share stimulus; expected flags from an
// integer reference model are queued at issue and popped by a negedge monitor.
module tb_magnitude_comparator_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gtIn;
  logic         eqIn;
  logic         ltIn;
  logic         outValidU, gtU, eqU, ltU;
  logic         outValidS, gtS, eqS, ltS;

  logic [2:0] expQU[$];
  logic [2:0] expQS[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  magnitude_comparator_4bit #(.WIDTH(W), .SIGNED(1'b0)) u_dutU (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .A(a), .B(b),
    .gt_in(gtIn), .eq_in(eqIn), .lt_in(ltIn),
    .out_valid(outValidU), .A_greater(gtU), .A_equal(eqU), .A_less(ltU)
  );

  magnitude_comparator_4bit #(.WIDTH(W), .SIGNED(1'b1)) u_dutS (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .A(a), .B(b),
    .gt_in(gtIn), .eq_in(eqIn), .lt_in(ltIn),
    .out_valid(outValidS), .A_greater(gtS), .A_equal(eqS), .A_less(ltS)
  );

  // Reference: operands as integers, compared arithmetically; cascade only on a tie.
  function automatic logic [2:0] refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input bit isSigned, input logic g, input logic l);
    int x;
    int y;
    x = int'(av);
    y = int'(bv);
    if (isSigned && av[W-1]) x = x - (1 << W);
    if (isSigned && bv[W-1]) y = y - (1 << W);
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    if (g) return 3'b100;
    if (l) return 3'b001;
    return 3'b010;
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic g, input logic e, input logic l);
    @(posedge clk);
    #1;
    rst_n   = rst;
    inValid = v;
    a       = av;
    b       = bv;
    gtIn    = g;
    eqIn    = e;
    ltIn    = l;
    if (rst && v) begin
      expQU.push_back(refModel(av, bv, 1'b0, g, l));
      expQS.push_back(refModel(av, bv, 1'b1, g, l));
    end
  endtask

  // Monitor: capture what the edge should do, then judge outputs on the falling edge.
  bit         started = 0;
  logic       expValid = 1'b0;
  logic       expRst = 1'b0;
  logic [2:0] heldU = 3'b000;
  logic [2:0] heldS = 3'b000;

  always @(posedge clk) begin
    expValid = rst_n && inValid;
    expRst   = !rst_n;
    started  = 1;
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (started) begin
      if (expRst) begin
        heldU = 3'b000;
        heldS = 3'b000;
      end
      checkOutput("validU", {2'b00, outValidU}, {2'b00, expValid});
      checkOutput("validS", {2'b00, outValidS}, {2'b00, expValid});
      if (outValidU) begin
        if (expQU.size() == 0) begin
          checkOutput("queueU", 3'b111, 3'b000);
        end else begin
          e = expQU.pop_front();
          checkOutput("flagsU", {gtU, eqU, ltU}, e);
          checkOutput("onehotU", {2'b00, $onehot({gtU, eqU, ltU})}, 3'b001);
          heldU = e;
        end
      end else begin
        checkOutput("holdU", {gtU, eqU, ltU}, heldU);
      end
      if (outValidS) begin
        if (expQS.size() == 0) begin
          checkOutput("queueS", 3'b111, 3'b000);
        end else begin
          e = expQS.pop_front();
          checkOutput("flagsS", {gtS, eqS, ltS}, e);
          checkOutput("onehotS", {2'b00, $onehot({gtS, eqS, ltS})}, 3'b001);
          heldS = e;
        end
      end else begin
        checkOutput("holdS", {gtS, eqS, ltS}, heldS);
      end
    end
  end

  initial begin
    logic [W-1:0] dirA[6] = '{4'b0101, 4'b1000, 4'b1010, 4'b0000, 4'b1111, 4'b0110};
    logic [W-1:0] dirB[6] = '{4'b0011, 4'b1111, 4'b1010, 4'b0001, 4'b0000, 4'b0101};
    logic [2:0]   cas;

    rst_n = 1'b0; inValid = 1'b1; a = 4'b0101; b = 4'b0011;
    gtIn = 1'b0; eqIn = 1'b1; ltIn = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Directed unsigned table, with an idle cycle after each to see one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, dirA[i], dirB[i], 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, dirA[i], dirB[i], 1'b0, 1'b1, 1'b0);
    end

    // Signed corner pairs and cascade behaviour.
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1110, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0011, 1'b0, 1'b0, 1'b1);

    // Idle with changing operands: flags must hold.
    applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0001, 1'b0, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep with random cascade inputs.
    for (int i = 0; i < 256; i++) begin
      cas = 3'($urandom_range(0, 7));
      applyStimulus(1'b1, 1'b1, 4'(i >> 4), 4'(i & 15), cas[2], cas[1], cas[0]);
    end

    // Random traffic with gaps.
    for (int i = 0; i < 60; i++) begin
      cas = 3'($urandom_range(0, 7));
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), cas[2], cas[1], cas[0]);
    end

    // Reset overrides a qualified input, then normal operation resumes.
    applyStimulus(1'b1, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("drainU", 3'(expQU.size()), 3'b000);
    checkOutput("drainS", 3'(expQS.size()), 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
